fan_ctrl_axil_regs: RTL and testbench
=====================================

// Module: fan_ctrl_axil_regs
// PURPOSE
//  AXI4-Lite responder (slave) and register bank for the Ultra96 fan controller.
//  Accepts single-beat writes and reads from the PS master, holds the PWM and threshold configuration
//  driven into the fan-control core, and exposes live temperature/alarm status.
//  Sits between the s00_axi port and the PWM/temperature logic. Replaces the vendor-template slave.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32     data bus width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  32     address width; bits [1:0] ignored
//  PERIOD_RST          4500   reset value of PWM_PERIOD
//  TEMP_HI_RST         16'hB000  reset value of TEMP_HI
//  TEMP_LO_RST         16'h9C40  reset value of TEMP_LO
// PORTS
//  s00_axi_aclk     in   1   clock
//  s00_axi_aresetn  in   1   async active-low reset
//  s00_axi_awaddr/awprot/awvalid in ADDR/3/1; s00_axi_awready out 1   write address channel
//  s00_axi_wdata/wstrb/wvalid  in 32/4/1; s00_axi_wready out 1         write data channel
//  s00_axi_bresp out 2; s00_axi_bvalid out 1; s00_axi_bready in 1      write response
//  s00_axi_araddr/arprot/arvalid in ADDR/3/1; s00_axi_arready out 1   read address channel
//  s00_axi_rdata out 32; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1
//  temp_in          in   16  raw temperature from sysmon
//  temp_alarm_in    in   1   over-temperature alarm, level
//  pwm_period       out  32  reg 0x00
//  force_full       out  1   CONTROL[0]
//  duty_hi/mid/lo   out  16 each  regs 0x0C/0x10/0x14 [15:0]
//  temp_hi/temp_lo  out  16 each  regs 0x18/0x1C [15:0]
// BEHAVIOUR
//  Map: 0x00 PWM_PERIOD RW | 0x04 STATUS RO/W1C | 0x08 CONTROL RW | 0x0C/10/14 DUTY_HI/MID/LO RW |
//   0x18 TEMP_HI RW | 0x1C TEMP_LO RW | >=0x20 unmapped. Unimplemented bits read 0.
//  STATUS: [15:0] temp_in registered every cycle, [16] alarm live, [17] alarm sticky; write 1 to bit 17 clears it.
//   Sticky set takes priority over a simultaneous clear.
//  Write: AW and W captured independently into one-deep holds, in either order or in the same cycle.
//   awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
//   Cycle after both holds are full: register updated per wstrb byte lanes, bvalid=1, holds cleared.
//   bvalid/bresp held until bready; no new AW/W accepted while bvalid=1.
//  Read: arready = !rvalid. The edge after the AR handshake registers rdata and sets rvalid=1; rdata/rresp stable until rready.
//  Same-edge write commit and read sample of one register: read returns the pre-write value.
//  Unmapped write: no state change. Unmapped read: rdata=0. resp per CONFIGURATION.
//  Reset (async assert, sync release): awready=wready=arready=0 while reset is asserted, then high.
//   bvalid=rvalid=0, bresp=rresp=0, rdata=0, holds empty, sticky=0, CONTROL=0, DUTY_*=0,
//   PWM_PERIOD/TEMP_* = *_RST. A reset mid-transaction drops the transaction; no B/R response is issued.
// CONFIGURATION
//  FAN_REGS_SLVERR_EN defined: unmapped access or any write to STATUS other than bit 17 -> resp 2'b10 SLVERR.
//  Not defined: every response is 2'b00 OKAY; bad accesses are silently ignored or read as 0.
// STRUCTURE
//  fan_ctrl_regs_pkg: register offsets, AXI resp codes (RESP_OKAY/RESP_SLVERR), field bit positions.
//  Sub-module fan_ctrl_axil_wr_hold: AW/W one-deep holds plus the B-channel handshake.
//  Decode and the read mux live in the top.
// TESTING
//  AW+W same cycle, addr 0x00 data 4500, strb F -> bvalid the next cycle, bresp 0, pwm_period=4500
//  W 4 cycles before AW, addr 0x0C data 0xFFF -> wready drops after W, write commits only after AW, duty_hi=0xFFF
//  bready held low 10 cycles -> bvalid stays 1, awready/wready stay 0, second write is not accepted early
//  strb 4'b0001 data 0xAABBCCDD to 0x10 (previous value 0x500) -> duty_mid=0x05DD
//  temp_alarm_in pulses 1 cycle, then read 0x04 -> bit17=1, bit16=0, [15:0]=temp_in; write 0x20000 -> bit17=0
//  Read 0x40 with rready low 5 cycles -> rvalid held, rdata=0, rresp=2'b10 with FAN_REGS_SLVERR_EN, else 0

Source files
------------

// File: rtl/fan_ctrl_regs_pkg.sv
// Shared definitions for the fan-controller AXI4-Lite register bank:
// register offsets, AXI response codes, field positions and byte-lane merge helpers.
package fan_ctrl_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Offsets within the 32-byte register window (address bits [4:0])
    localparam logic [4:0] OFS_PERIOD   = 5'h00;
    localparam logic [4:0] OFS_STATUS   = 5'h04;
    localparam logic [4:0] OFS_CONTROL  = 5'h08;
    localparam logic [4:0] OFS_DUTY_HI  = 5'h0C;
    localparam logic [4:0] OFS_DUTY_MID = 5'h10;
    localparam logic [4:0] OFS_DUTY_LO  = 5'h14;
    localparam logic [4:0] OFS_TEMP_HI  = 5'h18;
    localparam logic [4:0] OFS_TEMP_LO  = 5'h1C;

    localparam int STAT_ALARM_LIVE   = 16;
    localparam int STAT_ALARM_STICKY = 17;
    localparam int CTRL_FORCE_FULL   = 0;

    function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                            input logic [15:0] new_v,
                                            input logic [1:0]  strb);
        logic [15:0] res;
        for (int b = 0; b < 2; b++)
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++)
            m[b*8 +: 8] = {8{strb[b]}};
        return m;
    endfunction

endpackage

// File: rtl/fan_ctrl_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS master and the fan-controller register bank.
interface fan_ctrl_axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/fan_ctrl_axil_wr_hold.sv
// One-deep AW and W holds that accept the two channels in any order, plus the B-channel handshake.
// commit pulses for one cycle when both holds are full; the response code comes back from decode.
module fan_ctrl_axil_wr_hold #(
    parameter int ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              ready_en,
    input  logic [ADDR_W-1:2] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              commit,
    output logic [ADDR_W-1:2] commit_addr,
    output logic [31:0]       commit_data,
    output logic [3:0]        commit_strb,
    input  logic [1:0]        commit_resp
);
    logic aw_held, w_held;

    assign awready = ready_en && !aw_held && !bvalid;
    assign wready  = ready_en && !w_held && !bvalid;
    assign commit  = aw_held && w_held;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= commit_resp;
        end else begin
            if (awvalid && awready) aw_held <= 1'b1;
            if (wvalid && wready)   w_held  <= 1'b1;
            if (bvalid && bready)   bvalid  <= 1'b0;
        end
    end

    // Payload registers carry no reset; the held flags qualify them.
    always_ff @(posedge aclk) begin
        if (awvalid && awready) commit_addr <= awaddr;
        if (wvalid && wready) begin
            commit_data <= wdata;
            commit_strb <= wstrb;
        end
    end

endmodule

// File: rtl/fan_ctrl_axil_regs.sv
// AXI4-Lite register bank for the Ultra96 fan controller: PWM/threshold config plus temperature status.
// Define FAN_REGS_SLVERR_EN to answer unmapped accesses and illegal STATUS writes with SLVERR.
module fan_ctrl_axil_regs
    import fan_ctrl_regs_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [31:0] PERIOD_RST         = 32'd4500,
    parameter logic [15:0] TEMP_HI_RST        = 16'hB000,
    parameter logic [15:0] TEMP_LO_RST        = 16'h9C40
) (
    input  logic           s00_axi_aclk,
    input  logic           s00_axi_aresetn,
    fan_ctrl_axil_if.slave s00_axi,
    input  logic [15:0]    temp_in,
    input  logic           temp_alarm_in,
    output logic [31:0]    pwm_period,
    output logic           force_full,
    output logic [15:0]    duty_hi,
    output logic [15:0]    duty_mid,
    output logic [15:0]    duty_lo,
    output logic [15:0]    temp_hi,
    output logic [15:0]    temp_lo
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic          ready_en;
    logic          wr_commit;
    logic [AW-1:2] wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic [1:0]    wr_resp;
    logic          wr_mapped;
    logic [4:0]    wr_ofs;
    logic          sticky_clr;
    logic [15:0]   temp_q;
    logic          alarm_sticky;
    logic          rd_mapped;
    logic [DW-1:0] rd_word;
    logic [1:0]    rd_resp;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;
    logic          unused_bits;

    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    // Readies stay low until the first clock edge after reset release.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) ready_en <= 1'b0;
        else                  ready_en <= 1'b1;
    end

    fan_ctrl_axil_wr_hold #(.ADDR_W(AW)) u_wr_hold (
        .aclk        (s00_axi_aclk),
        .aresetn     (s00_axi_aresetn),
        .ready_en    (ready_en),
        .awaddr      (s00_axi.awaddr[AW-1:2]),
        .awvalid     (s00_axi.awvalid),
        .awready     (s00_axi.awready),
        .wdata       (s00_axi.wdata),
        .wstrb       (s00_axi.wstrb),
        .wvalid      (s00_axi.wvalid),
        .wready      (s00_axi.wready),
        .bresp       (s00_axi.bresp),
        .bvalid      (s00_axi.bvalid),
        .bready      (s00_axi.bready),
        .commit      (wr_commit),
        .commit_addr (wr_addr),
        .commit_data (wr_data),
        .commit_strb (wr_strb),
        .commit_resp (wr_resp)
    );

    assign wr_mapped  = (wr_addr[AW-1:5] == '0);
    assign wr_ofs     = {wr_addr[4:2], 2'b00};
    assign sticky_clr = wr_commit && wr_mapped && (wr_ofs == OFS_STATUS) &&
                        wr_strb[STAT_ALARM_STICKY/8] && wr_data[STAT_ALARM_STICKY];
    assign rd_mapped  = (s00_axi.araddr[AW-1:5] == '0);

`ifdef FAN_REGS_SLVERR_EN
    logic status_bad;
    assign status_bad = (wr_ofs == OFS_STATUS) &&
                        ((wr_data & strb_mask(wr_strb) & ~(32'd1 << STAT_ALARM_STICKY)) != '0);
    assign wr_resp = (!wr_mapped || status_bad) ? RESP_SLVERR : RESP_OKAY;
    assign rd_resp = rd_mapped ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            pwm_period   <= PERIOD_RST;
            force_full   <= 1'b0;
            duty_hi      <= 16'd0;
            duty_mid     <= 16'd0;
            duty_lo      <= 16'd0;
            temp_hi      <= TEMP_HI_RST;
            temp_lo      <= TEMP_LO_RST;
            temp_q       <= 16'd0;
            alarm_sticky <= 1'b0;
        end else begin
            temp_q <= temp_in;
            if (temp_alarm_in)   alarm_sticky <= 1'b1;
            else if (sticky_clr) alarm_sticky <= 1'b0;
            if (wr_commit && wr_mapped) begin
                case (wr_ofs)
                    OFS_PERIOD:   pwm_period <= merge32(pwm_period, wr_data, wr_strb);
                    OFS_CONTROL:  if (wr_strb[0]) force_full <= wr_data[CTRL_FORCE_FULL];
                    OFS_DUTY_HI:  duty_hi  <= merge16(duty_hi,  wr_data[15:0], wr_strb[1:0]);
                    OFS_DUTY_MID: duty_mid <= merge16(duty_mid, wr_data[15:0], wr_strb[1:0]);
                    OFS_DUTY_LO:  duty_lo  <= merge16(duty_lo,  wr_data[15:0], wr_strb[1:0]);
                    OFS_TEMP_HI:  temp_hi  <= merge16(temp_hi,  wr_data[15:0], wr_strb[1:0]);
                    OFS_TEMP_LO:  temp_lo  <= merge16(temp_lo,  wr_data[15:0], wr_strb[1:0]);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_mapped) begin
            case ({s00_axi.araddr[4:2], 2'b00})
                OFS_PERIOD: rd_word = pwm_period;
                OFS_STATUS: begin
                    rd_word[15:0]              = temp_q;
                    rd_word[STAT_ALARM_LIVE]   = temp_alarm_in;
                    rd_word[STAT_ALARM_STICKY] = alarm_sticky;
                end
                OFS_CONTROL:  rd_word[CTRL_FORCE_FULL] = force_full;
                OFS_DUTY_HI:  rd_word[15:0] = duty_hi;
                OFS_DUTY_MID: rd_word[15:0] = duty_mid;
                OFS_DUTY_LO:  rd_word[15:0] = duty_lo;
                OFS_TEMP_HI:  rd_word[15:0] = temp_hi;
                OFS_TEMP_LO:  rd_word[15:0] = temp_lo;
                default:      rd_word = '0;
            endcase
        end
    end

    assign s00_axi.arready = ready_en && !rvalid_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = rresp_q;

    // Read data is captured on the AR handshake edge, so a same-edge write is not yet visible.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else if (s00_axi.arvalid && s00_axi.arready) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= rd_resp;
        end else if (rvalid_q && s00_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fan_ctrl_axil_regs.sv
// Directed bench for fan_ctrl_axil_regs: handshake ordering, byte strobes, status sticky bit,
// unmapped access and reset behaviour. Honours FAN_REGS_SLVERR_EN for the expected error response.
module tb_fan_ctrl_axil_regs;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [15:0] temp_in;
    logic        temp_alarm_in;
    logic [31:0] pwm_period;
    logic        force_full;
    logic [15:0] duty_hi, duty_mid, duty_lo, temp_hi, temp_lo;
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef FAN_REGS_SLVERR_EN
    localparam logic [1:0] EXP_ERR = 2'b10;
`else
    localparam logic [1:0] EXP_ERR = 2'b00;
`endif

    fan_ctrl_axil_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    fan_ctrl_axil_regs dut (
        .s00_axi_aclk    (aclk),
        .s00_axi_aresetn (aresetn),
        .s00_axi         (axi),
        .temp_in         (temp_in),
        .temp_alarm_in   (temp_alarm_in),
        .pwm_period      (pwm_period),
        .force_full      (force_full),
        .duty_hi         (duty_hi),
        .duty_mid        (duty_mid),
        .duty_lo         (duty_lo),
        .temp_hi         (temp_hi),
        .temp_lo         (temp_lo)
    );

    always #5 aclk = ~aclk;

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_now, w_now, got_b;
        aw_done = 0; w_done = 0; got_b = 0; resp = 2'b11;
        @(negedge aclk);
        axi.awaddr = a; axi.awvalid = 1'b1;
        axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
        for (int i = 0; i < 40 && !(aw_done && w_done); i++) begin
            aw_now = axi.awvalid && axi.awready;
            w_now  = axi.wvalid && axi.wready;
            @(posedge aclk); #1;
            if (aw_now) begin axi.awvalid = 1'b0; aw_done = 1; end
            if (w_now)  begin axi.wvalid = 1'b0;  w_done = 1;  end
            @(negedge aclk);
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        for (int i = 0; i < 40 && !got_b; i++) begin
            if (axi.bvalid === 1'b1) begin
                resp = axi.bresp; got_b = 1; axi.bready = 1'b1;
                @(posedge aclk); #1; axi.bready = 1'b0;
            end else @(negedge aclk);
        end
        n_cmp++;
        if (!got_b) begin n_err++; $display("FAIL wr_timeout addr=%h bvalid got=0 exp=1", a); end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_done, ar_now, got_r;
        ar_done = 0; got_r = 0; d = 32'hDEAD_BEEF; resp = 2'b11;
        @(negedge aclk);
        axi.araddr = a; axi.arvalid = 1'b1;
        for (int i = 0; i < 40 && !ar_done; i++) begin
            ar_now = axi.arready;
            @(posedge aclk); #1;
            if (ar_now) begin axi.arvalid = 1'b0; ar_done = 1; end
            @(negedge aclk);
        end
        axi.arvalid = 1'b0;
        for (int i = 0; i < 40 && !got_r; i++) begin
            if (axi.rvalid === 1'b1) begin
                d = axi.rdata; resp = axi.rresp; got_r = 1; axi.rready = 1'b1;
                @(posedge aclk); #1; axi.rready = 1'b0;
            end else @(negedge aclk);
        end
        n_cmp++;
        if (!got_r) begin n_err++; $display("FAIL rd_timeout addr=%h rvalid got=0 exp=1", a); end
    endtask

    task automatic test_reset();
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0;
        axi.wvalid = 0; axi.bready = 0; axi.araddr = '0; axi.arprot = '0; axi.arvalid = 0;
        axi.rready = 0; temp_in = 16'h0000; temp_alarm_in = 0;
        #2 aresetn = 1'b0;
        #4;
        n_cmp++; if (axi.awready !== 1'b0) begin n_err++; $display("FAIL rst_awready got=%b exp=0", axi.awready); end
        n_cmp++; if (axi.wready !== 1'b0) begin n_err++; $display("FAIL rst_wready got=%b exp=0", axi.wready); end
        n_cmp++; if (axi.arready !== 1'b0) begin n_err++; $display("FAIL rst_arready got=%b exp=0", axi.arready); end
        n_cmp++; if (axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0) begin n_err++; $display("FAIL rst_valids got=%b%b exp=00", axi.bvalid, axi.rvalid); end
        n_cmp++; if (axi.rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got=%h exp=0", axi.rdata); end
        n_cmp++; if (pwm_period !== 32'd4500) begin n_err++; $display("FAIL rst_period got=%0d exp=4500", pwm_period); end
        n_cmp++; if (temp_hi !== 16'hB000 || temp_lo !== 16'h9C40) begin n_err++; $display("FAIL rst_temp got=%h/%h exp=b000/9c40", temp_hi, temp_lo); end
        n_cmp++; if ({force_full, duty_hi, duty_mid, duty_lo} !== 49'h0) begin n_err++; $display("FAIL rst_ctrl_duty got=%b %h %h %h exp=0", force_full, duty_hi, duty_mid, duty_lo); end
        @(negedge aclk); aresetn = 1'b1;
        @(negedge aclk);
        n_cmp++; if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin n_err++; $display("FAIL rst_release_ready got=%b exp=111", {axi.awready, axi.wready, axi.arready}); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d; logic [1:0] r;
        @(negedge aclk);
        axi.awaddr = 32'h00; axi.awvalid = 1; axi.wdata = 32'd4500; axi.wstrb = 4'hF; axi.wvalid = 1;
        n_cmp++; if ({axi.awready, axi.wready} !== 2'b11) begin n_err++; $display("FAIL sc_ready got=%b exp=11", {axi.awready, axi.wready}); end
        @(posedge aclk); #1; axi.awvalid = 0; axi.wvalid = 0;
        @(negedge aclk);
        n_cmp++; if (axi.bvalid !== 1'b0) begin n_err++; $display("FAIL sc_bvalid_early got=%b exp=0", axi.bvalid); end
        @(negedge aclk);
        n_cmp++; if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin n_err++; $display("FAIL sc_bresp got=%b/%b exp=1/00", axi.bvalid, axi.bresp); end
        n_cmp++; if (pwm_period !== 32'd4500) begin n_err++; $display("FAIL sc_period got=%0d exp=4500", pwm_period); end
        axi.bready = 1; @(posedge aclk); #1; axi.bready = 0;
        @(negedge aclk);
        n_cmp++; if (axi.bvalid !== 1'b0) begin n_err++; $display("FAIL sc_bvalid_drop got=%b exp=0", axi.bvalid); end
        axi_write(32'h00, 32'h0001_2345, 4'hF, r);
        n_cmp++; if (pwm_period !== 32'h0001_2345 || r !== 2'b00) begin n_err++; $display("FAIL sc_period2 got=%h/%b exp=00012345/00", pwm_period, r); end
        axi_read(32'h00, d, r);
        n_cmp++; if (d !== 32'h0001_2345 || r !== 2'b00) begin n_err++; $display("FAIL sc_readback got=%h/%b exp=00012345/00", d, r); end
    endtask

    task automatic test_w_before_aw();
        @(negedge aclk);
        axi.wdata = 32'h0000_0FFF; axi.wstrb = 4'hF; axi.wvalid = 1;
        n_cmp++; if (axi.wready !== 1'b1) begin n_err++; $display("FAIL wa_wready got=%b exp=1", axi.wready); end
        @(posedge aclk); #1; axi.wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_cmp++; if ({axi.wready, axi.bvalid} !== 2'b00 || duty_hi !== 16'h0) begin n_err++; $display("FAIL wa_wait%0d got=%b%b duty=%h exp=00 duty=0", i, axi.wready, axi.bvalid, duty_hi); end
        end
        @(negedge aclk);
        axi.awaddr = 32'h0C; axi.awvalid = 1;
        n_cmp++; if (axi.awready !== 1'b1) begin n_err++; $display("FAIL wa_awready got=%b exp=1", axi.awready); end
        @(posedge aclk); #1; axi.awvalid = 0;
        @(negedge aclk);
        n_cmp++; if (axi.bvalid !== 1'b0 || duty_hi !== 16'h0) begin n_err++; $display("FAIL wa_precommit got=%b duty=%h exp=0 duty=0", axi.bvalid, duty_hi); end
        @(negedge aclk);
        n_cmp++; if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00 || duty_hi !== 16'h0FFF) begin n_err++; $display("FAIL wa_commit got=%b/%b duty=%h exp=1/00 duty=0fff", axi.bvalid, axi.bresp, duty_hi); end
        axi.bready = 1; @(posedge aclk); #1; axi.bready = 0;
    endtask

    task automatic test_back_to_back();
        @(negedge aclk);
        axi.awaddr = 32'h14; axi.awvalid = 1; axi.wdata = 32'h0777; axi.wstrb = 4'hF; axi.wvalid = 1;
        @(posedge aclk); #1; axi.awvalid = 0; axi.wvalid = 0;
        @(posedge aclk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            n_cmp++; if ({axi.bvalid, axi.awready, axi.wready} !== 3'b100) begin n_err++; $display("FAIL b2b_stall%0d got=%b exp=100", i, {axi.bvalid, axi.awready, axi.wready}); end
            if (i == 0) begin
                axi.awaddr = 32'h14; axi.awvalid = 1; axi.wdata = 32'h0123; axi.wstrb = 4'hF; axi.wvalid = 1;
            end
        end
        n_cmp++; if (duty_lo !== 16'h0777) begin n_err++; $display("FAIL b2b_first got=%h exp=0777", duty_lo); end
        axi.bready = 1; @(posedge aclk); #1; axi.bready = 0;
        @(negedge aclk);
        n_cmp++; if ({axi.bvalid, axi.awready, axi.wready} !== 3'b011) begin n_err++; $display("FAIL b2b_reopen got=%b exp=011", {axi.bvalid, axi.awready, axi.wready}); end
        @(posedge aclk); #1; axi.awvalid = 0; axi.wvalid = 0;
        @(negedge aclk);
        @(negedge aclk);
        n_cmp++; if (axi.bvalid !== 1'b1 || duty_lo !== 16'h0123) begin n_err++; $display("FAIL b2b_second got=%b duty=%h exp=1 duty=0123", axi.bvalid, duty_lo); end
        axi.bready = 1; @(posedge aclk); #1; axi.bready = 0;
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r;
        axi_write(32'h10, 32'h0000_0500, 4'hF, r);
        axi_write(32'h10, 32'hAABB_CCDD, 4'b0001, r);
        n_cmp++; if (duty_mid !== 16'h05DD) begin n_err++; $display("FAIL strb_duty_mid got=%h exp=05dd", duty_mid); end
        axi_read(32'h10, d, r);
        n_cmp++; if (d !== 32'h0000_05DD) begin n_err++; $display("FAIL strb_readback got=%h exp=000005dd", d); end
    endtask

    task automatic test_control_temp();
        logic [31:0] d; logic [1:0] r;
        axi_read(32'h18, d, r);
        n_cmp++; if (d !== 32'h0000_B000) begin n_err++; $display("FAIL temp_hi_default got=%h exp=0000b000", d); end
        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, r);
        n_cmp++; if (force_full !== 1'b1) begin n_err++; $display("FAIL ctrl_force got=%b exp=1", force_full); end
        axi_read(32'h08, d, r);
        n_cmp++; if (d !== 32'h0000_0001) begin n_err++; $display("FAIL ctrl_readback got=%h exp=00000001", d); end
        axi_write(32'h18, 32'hDEAD_BEEF, 4'hF, r);
        n_cmp++; if (temp_hi !== 16'hBEEF) begin n_err++; $display("FAIL temp_hi_wr got=%h exp=beef", temp_hi); end
        axi_read(32'h1C, d, r);
        n_cmp++; if (d !== 32'h0000_9C40) begin n_err++; $display("FAIL temp_lo_default got=%h exp=00009c40", d); end
    endtask

    task automatic test_status();
        logic [31:0] d; logic [1:0] r;
        temp_in = 16'h1234;
        @(negedge aclk); temp_alarm_in = 1;
        @(posedge aclk); #1; temp_alarm_in = 0;
        axi_read(32'h04, d, r);
        n_cmp++; if (d !== 32'h0002_1234 || r !== 2'b00) begin n_err++; $display("FAIL stat_sticky got=%h/%b exp=00021234/00", d, r); end
        axi_write(32'h04, 32'h0002_0000, 4'hF, r);
        n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL stat_clr_resp got=%b exp=00", r); end
        axi_read(32'h04, d, r);
        n_cmp++; if (d !== 32'h0000_1234) begin n_err++; $display("FAIL stat_cleared got=%h exp=00001234", d); end
        axi_write(32'h04, 32'h0000_0001, 4'hF, r);
        n_cmp++; if (r !== EXP_ERR) begin n_err++; $display("FAIL stat_bad_resp got=%b exp=%b", r, EXP_ERR); end
        temp_alarm_in = 1;
        axi_write(32'h04, 32'h0002_0000, 4'hF, r);
        axi_read(32'h04, d, r);
        n_cmp++; if (d !== 32'h0003_1234) begin n_err++; $display("FAIL stat_set_priority got=%h exp=00031234", d); end
        temp_alarm_in = 0;
        axi_write(32'h04, 32'h0002_0000, 4'b0100, r);
        axi_read(32'h04, d, r);
        n_cmp++; if (d !== 32'h0000_1234) begin n_err++; $display("FAIL stat_clr_lane2 got=%h exp=00001234", d); end
    endtask

    task automatic test_unmapped();
        logic [1:0] r;
        @(negedge aclk);
        axi.araddr = 32'h40; axi.arvalid = 1; axi.rready = 0;
        n_cmp++; if (axi.arready !== 1'b1) begin n_err++; $display("FAIL um_arready got=%b exp=1", axi.arready); end
        @(posedge aclk); #1; axi.arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            n_cmp++; if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h0 || axi.rresp !== EXP_ERR || axi.arready !== 1'b0) begin
                n_err++; $display("FAIL um_rd_hold%0d got=%b/%h/%b exp=1/00000000/%b", i, axi.rvalid, axi.rdata, axi.rresp, EXP_ERR); end
        end
        axi.rready = 1; @(posedge aclk); #1; axi.rready = 0;
        @(negedge aclk);
        n_cmp++; if (axi.rvalid !== 1'b0) begin n_err++; $display("FAIL um_rvalid_drop got=%b exp=0", axi.rvalid); end
        axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, r);
        n_cmp++; if (r !== EXP_ERR) begin n_err++; $display("FAIL um_wr_resp got=%b exp=%b", r, EXP_ERR); end
        n_cmp++; if (pwm_period !== 32'h0001_2345 || duty_hi !== 16'h0FFF || temp_lo !== 16'h9C40) begin
            n_err++; $display("FAIL um_wr_nochange got=%h/%h/%h exp=00012345/0fff/9c40", pwm_period, duty_hi, temp_lo); end
    endtask

    task automatic test_reset_mid();
        @(negedge aclk);
        axi.awaddr = 32'h0C; axi.awvalid = 1; axi.wdata = 32'h0ABC; axi.wstrb = 4'hF; axi.wvalid = 1;
        @(posedge aclk); #1; axi.awvalid = 0; axi.wvalid = 0;
        #2 aresetn = 1'b0;
        #1;
        n_cmp++; if (duty_hi !== 16'h0 || pwm_period !== 32'd4500 || force_full !== 1'b0 || temp_hi !== 16'hB000) begin
            n_err++; $display("FAIL rm_regs got=%h/%0d/%b/%h exp=0000/4500/0/b000", duty_hi, pwm_period, force_full, temp_hi); end
        n_cmp++; if (axi.awready !== 1'b0) begin n_err++; $display("FAIL rm_awready got=%b exp=0", axi.awready); end
        @(negedge aclk); aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_cmp++; if (axi.bvalid !== 1'b0) begin n_err++; $display("FAIL rm_no_b%0d got=%b exp=0", i, axi.bvalid); end
        end
        n_cmp++; if (duty_hi !== 16'h0) begin n_err++; $display("FAIL rm_dropped got=%h exp=0000", duty_hi); end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_back_to_back();
        test_strobe();
        test_control_temp();
        test_status();
        test_unmapped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
